// File: rtl/mdu_exeunit.sv
// mdu_exeunit: iterative RV32M multiply/divide unit with valid/ready handshake and flush
//   in_valid/in_ready/in_op/in_rs1/in_rs2/in_rd : operation request, accepted only in IDLE
//   out_valid/out_ready/out_result/out_rd       : result, held until accepted
//   flush aborts any operation; busy is high whenever the unit is not IDLE
module mdu_exeunit #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [REGW-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [REGW-1:0] out_rd,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    state_t          r_state;
    logic [2:0]      r_op;
    logic [REGW-1:0] r_rd;
    logic [XLEN-1:0] r_a, r_b, r_rem, r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_res, r_neg_rem;
    logic            w_sa, w_sb, w_na, w_nb, w_div0, w_ovf, w_ge;
    logic [XLEN-1:0] w_ma, w_mb, w_spec, w_quo, w_rm, w_fix;
    logic [XLEN:0]   w_sum, w_shift, w_trial;
    logic [2*XLEN-1:0] w_prod;
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign w_sa   = (in_op == 3'd1) || (in_op == 3'd2) || (in_op[2] && !in_op[0]);
    assign w_sb   = (in_op == 3'd1) || (in_op[2] && !in_op[0]);
    assign w_na   = w_sa && in_rs1[XLEN-1];
    assign w_nb   = w_sb && in_rs2[XLEN-1];
    assign w_ma   = w_na ? -in_rs1 : in_rs1;
    assign w_mb   = w_nb ? -in_rs2 : in_rs2;
    assign w_div0 = in_op[2] && (in_rs2 == '0);
    assign w_ovf  = in_op[2] && !in_op[0] && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
    assign w_spec = w_div0 ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : in_rs1);
    // shift-add: acc holds {partial product, remaining multiplier bits}
    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    // restoring divide: acc low half shifts dividend out and quotient bits in
    assign w_shift = {r_rem, r_acc[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_b};
    assign w_ge    = !w_trial[XLEN];
    assign w_prod  = r_neg_res ? -r_acc : r_acc;
    assign w_quo   = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rm    = r_neg_rem ? -r_rem : r_rem;
    assign w_fix   = r_op[2] ? (r_op[1] ? w_rm : w_quo)
                             : ((r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_result  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op      <= in_op;
                    r_rd      <= in_rd;
                    r_a       <= w_ma;
                    r_b       <= w_mb;
                    r_acc     <= {{XLEN{1'b0}}, in_op[2] ? w_ma : w_mb};
                    r_rem     <= '0;
                    r_cnt     <= '0;
                    r_neg_res <= w_na ^ w_nb;
                    r_neg_rem <= w_na;
                    if (w_div0 || w_ovf) r_result <= w_spec;
                    r_state   <= (w_div0 || w_ovf) ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    r_acc <= r_op[2] ? {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_ge}
                                     : {w_sum, r_acc[XLEN-1:1]};
                    if (r_op[2]) r_rem <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_state  <= S_DONE;
                end
                default: if (out_ready) r_state <= S_IDLE;
            endcase
        end
    end
    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_result;
    assign out_rd     = r_rd;
endmodule

// File: tb/tb_mdu_exeunit.sv
// tb_mdu_exeunit: directed vector and corner-sequence checks for mdu_exeunit
module tb_mdu_exeunit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[18];
    mdu_exeunit #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat);
        in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; in_valid = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
    endtask
    initial begin
        int lat;
        logic seen;
        vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd1, 32'h80000000,  32'h80000000, 5'd2,  32'h40000000, 34};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 34};
        vecs[3]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        5'd5,  32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        5'd6,  32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,        5'd7,  32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,        5'd8,  32'd2,        34};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,        5'd9,  32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,        5'd10, 32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 5'd12, 32'd0,        1};
        vecs[12] = '{3'd1, 32'hFFFFFFFD,  32'd5,        5'd13, 32'hFFFFFFFF, 34};
        vecs[13] = '{3'd3, 32'h80000000,  32'd4,        5'd14, 32'd2,        34};
        vecs[14] = '{3'd4, 32'd7,         32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 34};
        vecs[15] = '{3'd6, 32'd7,         32'hFFFFFFFE, 5'd16, 32'd1,        34};
        vecs[16] = '{3'd7, 32'd7,         32'd0,        5'd17, 32'd7,        1};
        vecs[17] = '{3'd4, 32'd5,         32'd0,        5'd18, 32'hFFFFFFFF, 1};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].exp);
            chk($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle", i), in_ready, 1);
        end
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd9, lat);
        chk("bp_latency", lat, 34);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_result", out_result, 32'd14);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, lat);
        chk("bp_next_result", out_result, 32'hFFFFFFFE);
        chk("bp_next_rd", out_rd, 5'd20);
        @(posedge clk); #1;
        in_op = 3'd5; in_rs1 = 32'd50; in_rs2 = 32'd5; in_rd = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fl_started", busy, 1);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("fl_in_ready", in_ready, 1);
        chk("fl_busy", busy, 0);
        chk("fl_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("fl_no_result", seen, 0);
        in_op = 3'd0; in_rs1 = 32'd3; in_rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flv_in_ready", in_ready, 1);
        chk("flv_busy", busy, 0);
        in_op = 3'd3; in_rs1 = 32'hFFFFFFFF; in_rs2 = 32'hFFFFFFFF; in_rd = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_result", out_result, 0);
        chk("mr_rd", out_rd, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        issue(3'd5, 32'd9, 32'd3, 5'd2, lat);
        chk("mr_next_latency", lat, 34);
        chk("mr_next_result", out_result, 32'd3);
        chk("mr_next_rd", out_rd, 5'd2);
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
